// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared RV32I decode codes, opcodes, funct fields and immediate helpers
package decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_UNUSED, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
    ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_JAL, ALU_JALR,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_e;

  typedef enum logic [2:0] {NOTLOAD, LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU} load_e;
  typedef enum logic [1:0] {NOTSTORE, ST_SB, ST_SH, ST_SW} store_e;
  typedef enum logic [3:0] {
    NOTBRANCH, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU, BR_JAL, BR_JALR
  } branch_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    alu_e        alucode;
    logic        using_r2;
    logic        using_pc;
    logic        write_reg;
    load_e       info_load;
    store_e      info_store;
    branch_e     info_branch;
    logic        illegal;
    logic [31:0] imm;
  } dec_t;

  localparam dec_t DEC_IDLE = '{
    rs1: 5'd0, rs2: 5'd0, rd: 5'd0, alucode: ALU_UNUSED,
    using_r2: 1'b0, using_pc: 1'b0, write_reg: 1'b0,
    info_load: NOTLOAD, info_store: NOTSTORE, info_branch: NOTBRANCH,
    illegal: 1'b0, imm: 32'd0
  };

  function automatic logic [31:0] imm_i(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:25], ir[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ir);
    return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ir);
    return {ir[31:12], 12'd0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ir);
    return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  endfunction

  // alt picks SUB/SRA; callers gate it so ADDI's imm bit 30 cannot leak in
  function automatic alu_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD_SUB: return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
      F3_OR:      return ALU_OR;
      default:    return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - combinational RV32I field decode; RV_M_EXT_EN enables MUL/DIV decode
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       bad;

  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7     = ir[31:25];

  always_comb begin
    dec = DEC_IDLE;
    bad = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        dec.rs1       = ir[19:15];
        dec.rd        = ir[11:7];
        dec.write_reg = 1'b1;
        dec.imm       = imm_i(ir);
        dec.alucode   = alu_from_f3(f3, (f3 == F3_SRL_SRA) && ir[30]);
        if (f3 == F3_SLL || f3 == F3_SRL_SRA)
          dec.imm = {27'd0, ir[24:20]};
      end
      OPC_OP: begin
        dec.rs1       = ir[19:15];
        dec.rs2       = ir[24:20];
        dec.rd        = ir[11:7];
        dec.using_r2  = 1'b1;
        dec.write_reg = 1'b1;
        if (f7 == F7_MULDIV) begin
`ifdef RV_M_EXT_EN
          case (f3)
            3'b000:  dec.alucode = ALU_MUL;
            3'b001:  dec.alucode = ALU_MULH;
            3'b010:  dec.alucode = ALU_MULHSU;
            3'b011:  dec.alucode = ALU_MULHU;
            3'b100:  dec.alucode = ALU_DIV;
            3'b101:  dec.alucode = ALU_DIVU;
            3'b110:  dec.alucode = ALU_REM;
            default: dec.alucode = ALU_REMU;
          endcase
`else
          bad = 1'b1;
`endif
        end else if (f7 == F7_BASE ||
                     (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA))) begin
          dec.alucode = alu_from_f3(f3, ir[30]);
        end else begin
          bad = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.rd        = ir[11:7];
        dec.write_reg = 1'b1;
        dec.imm       = imm_u(ir);
        dec.alucode   = ALU_LUI;
      end
      OPC_AUIPC: begin
        dec.rd        = ir[11:7];
        dec.write_reg = 1'b1;
        dec.using_pc  = 1'b1;
        dec.imm       = imm_u(ir);
        dec.alucode   = ALU_ADD;
      end
      OPC_JAL: begin
        dec.rd          = ir[11:7];
        dec.write_reg   = 1'b1;
        dec.using_pc    = 1'b1;
        dec.imm         = imm_j(ir);
        dec.alucode     = ALU_JAL;
        dec.info_branch = BR_JAL;
      end
      OPC_JALR: begin
        dec.rs1         = ir[19:15];
        dec.rd          = ir[11:7];
        dec.write_reg   = 1'b1;
        dec.imm         = imm_i(ir);
        dec.alucode     = ALU_JALR;
        dec.info_branch = BR_JALR;
      end
      OPC_BRANCH: begin
        dec.rs1      = ir[19:15];
        dec.rs2      = ir[24:20];
        dec.using_r2 = 1'b1;
        dec.using_pc = 1'b1;
        dec.imm      = imm_b(ir);
        dec.alucode  = ALU_ADD;
        case (f3)
          F3_BEQ:  dec.info_branch = BR_BEQ;
          F3_BNE:  dec.info_branch = BR_BNE;
          F3_BLT:  dec.info_branch = BR_BLT;
          F3_BGE:  dec.info_branch = BR_BGE;
          F3_BLTU: dec.info_branch = BR_BLTU;
          F3_BGEU: dec.info_branch = BR_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.rs1      = ir[19:15];
        dec.rs2      = ir[24:20];
        dec.using_r2 = 1'b1;
        dec.imm      = imm_s(ir);
        dec.alucode  = ALU_ADD;
        case (f3)
          F3_SB:   dec.info_store = ST_SB;
          F3_SH:   dec.info_store = ST_SH;
          F3_SW:   dec.info_store = ST_SW;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.rs1       = ir[19:15];
        dec.rd        = ir[11:7];
        dec.write_reg = 1'b1;
        dec.imm       = imm_i(ir);
        dec.alucode   = ALU_ADD;
        case (f3)
          F3_LB:   dec.info_load = LD_LB;
          F3_LH:   dec.info_load = LD_LH;
          F3_LW:   dec.info_load = LD_LW;
          F3_LBU:  dec.info_load = LD_LBU;
          F3_LHU:  dec.info_load = LD_LHU;
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase

    // an undecodable word carries no fields, only the flag
    if (bad) begin
      dec         = DEC_IDLE;
      dec.illegal = 1'b1;
    end
    dec.write_reg = dec.write_reg && (dec.rd != 5'd0);
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode pipeline stage: output register plus skid entry; RV_M_EXT_EN selects MUL/DIV decode
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ALU_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ir,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       srcreg1_num,
  output logic [4:0]       srcreg2_num,
  output logic [4:0]       dstreg_num,
  output logic [XLEN-1:0]  imm,
  output logic [ALU_W-1:0] alucode,
  output logic             using_r2,
  output logic             using_pc,
  output logic             write_reg,
  output logic [2:0]       info_load,
  output logic [1:0]       info_store,
  output logic [3:0]       info_branch,
  output logic [XLEN-1:0]  pc2,
  output logic             illegal
);

  dec_t            in_dec;
  dec_t            out_q;
  dec_t            skid_q;
  logic [XLEN-1:0] out_pc_q;
  logic [XLEN-1:0] skid_pc_q;
  logic            out_valid_q;
  logic            skid_valid_q;
  logic            in_ready_q;
  logic            accept;
  logic            out_free;

  decode_comb u_decode_comb (
    .ir  (in_ir),
    .dec (in_dec)
  );

  assign accept   = in_valid && in_ready_q && !flush;
  assign out_free = !out_valid_q || out_ready;

  // in_ready_q tracks !skid_valid but is its own flop so it stays 0 during reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= DEC_IDLE;
      skid_q       <= DEC_IDLE;
      out_pc_q     <= '0;
      skid_pc_q    <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else if (flush) begin
      out_q        <= DEC_IDLE;
      out_pc_q     <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      in_ready_q <= !skid_valid_q;
      if (out_free) begin
        if (skid_valid_q) begin
          out_q        <= skid_q;
          out_pc_q     <= skid_pc_q;
          out_valid_q  <= 1'b1;
          skid_valid_q <= 1'b0;
          in_ready_q   <= 1'b1;
        end else if (accept) begin
          out_q       <= in_dec;
          out_pc_q    <= in_pc;
          out_valid_q <= 1'b1;
        end else begin
          out_q       <= DEC_IDLE;
          out_pc_q    <= '0;
          out_valid_q <= 1'b0;
        end
      end else if (accept) begin
        skid_q       <= in_dec;
        skid_pc_q    <= in_pc;
        skid_valid_q <= 1'b1;
        in_ready_q   <= 1'b0;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign srcreg1_num = out_q.rs1;
  assign srcreg2_num = out_q.rs2;
  assign dstreg_num  = out_q.rd;
  assign imm         = XLEN'($signed(out_q.imm));
  assign alucode     = ALU_W'(out_q.alucode);
  assign using_r2    = out_q.using_r2;
  assign using_pc    = out_q.using_pc;
  assign write_reg   = out_q.write_reg;
  assign info_load   = out_q.info_load;
  assign info_store  = out_q.info_store;
  assign info_branch = out_q.info_branch;
  assign illegal     = out_q.illegal;
  assign pc2         = out_pc_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage; expectations follow RV_M_EXT_EN
module tb_decode_stage;
  import decode_pkg::*;

  localparam int XLEN  = 32;
  localparam int ALU_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_ir;
  logic [XLEN-1:0]  in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       srcreg1_num, srcreg2_num, dstreg_num;
  logic [XLEN-1:0]  imm, pc2;
  logic [ALU_W-1:0] alucode;
  logic             using_r2, using_pc, write_reg, illegal;
  logic [2:0]       info_load;
  logic [1:0]       info_store;
  logic [3:0]       info_branch;

  decode_stage #(.XLEN(XLEN), .ALU_W(ALU_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .srcreg1_num(srcreg1_num), .srcreg2_num(srcreg2_num),
    .dstreg_num(dstreg_num), .imm(imm), .alucode(alucode), .using_r2(using_r2),
    .using_pc(using_pc), .write_reg(write_reg), .info_load(info_load),
    .info_store(info_store), .info_branch(info_branch), .pc2(pc2), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic        r2, upc, wr;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [3:0]  br;
    logic        ill;
  } vec_t;

  vec_t tbl[$];
  int   sb[$];
  int   checks = 0;
  int   passed = 0;

  function automatic vec_t mk(logic [31:0] ir, logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic [31:0] im, logic [4:0] alu, logic r2,
                              logic upc, logic wr, logic [2:0] ld, logic [1:0] st,
                              logic [3:0] br, logic ill);
    vec_t v;
    v.ir = ir; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.imm = im; v.alu = alu;
    v.r2 = r2; v.upc = upc; v.wr = wr; v.ld = ld; v.st = st; v.br = br; v.ill = ill;
    return v;
  endfunction

  function automatic vec_t bad(logic [31:0] ir, logic [31:0] pc);
    return mk(ir, pc, 0, 0, 0, 0, ALU_UNUSED, 0, 0, 0, NOTLOAD, NOTSTORE, NOTBRANCH, 1);
  endfunction

  task automatic build_table();
    tbl.push_back(mk(32'hFFF08293, 32'h000, 1, 0, 5, 32'hFFFFFFFF, ALU_ADD, 0, 0, 1, NOTLOAD, NOTSTORE, NOTBRANCH, 0));
    tbl.push_back(mk(32'h00208463, 32'h100, 1, 2, 0, 32'h8, ALU_ADD, 1, 1, 0, NOTLOAD, NOTSTORE, BR_BEQ, 0));
`ifdef RV_M_EXT_EN
    tbl.push_back(mk(32'h02208033, 32'h104, 1, 2, 0, 32'h0, ALU_MUL, 1, 0, 0, NOTLOAD, NOTSTORE, NOTBRANCH, 0));
`else
    tbl.push_back(bad(32'h02208033, 32'h104));
`endif
    tbl.push_back(mk(32'h402081B3, 32'h108, 1, 2, 3, 32'h0, ALU_SUB, 1, 0, 1, NOTLOAD, NOTSTORE, NOTBRANCH, 0));
    tbl.push_back(mk(32'h123453B7, 32'h10C, 0, 0, 7, 32'h12345000, ALU_LUI, 0, 0, 1, NOTLOAD, NOTSTORE, NOTBRANCH, 0));
    tbl.push_back(mk(32'h01012303, 32'h110, 2, 0, 6, 32'h10, ALU_ADD, 0, 0, 1, LD_LW, NOTSTORE, NOTBRANCH, 0));
    tbl.push_back(mk(32'hFE50AE23, 32'h114, 1, 5, 0, 32'hFFFFFFFC, ALU_ADD, 1, 0, 0, NOTLOAD, ST_SW, NOTBRANCH, 0));
    tbl.push_back(mk(32'h4031D213, 32'h118, 3, 0, 4, 32'h3, ALU_SRA, 0, 0, 1, NOTLOAD, NOTSTORE, NOTBRANCH, 0));
    tbl.push_back(mk(32'h010000EF, 32'h11C, 0, 0, 1, 32'h10, ALU_JAL, 0, 1, 1, NOTLOAD, NOTSTORE, BR_JAL, 0));
    tbl.push_back(mk(32'h00000013, 32'h120, 0, 0, 0, 32'h0, ALU_ADD, 0, 0, 0, NOTLOAD, NOTSTORE, NOTBRANCH, 0));
    tbl.push_back(bad(32'hFFFFFFFF, 32'h124));
    tbl.push_back(bad(32'h00013003, 32'h128));
    tbl.push_back(bad(32'h00002063, 32'h12C));
    tbl.push_back(bad(32'h00003023, 32'h130));
    tbl.push_back(mk(32'h00001517, 32'h134, 0, 0, 10, 32'h1000, ALU_ADD, 0, 1, 1, NOTLOAD, NOTSTORE, NOTBRANCH, 0));
    tbl.push_back(mk(32'h00008067, 32'h138, 1, 0, 0, 32'h0, ALU_JALR, 0, 0, 0, NOTLOAD, NOTSTORE, BR_JALR, 0));
  endtask

  function automatic logic [96:0] exp_of(int i);
    return {tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].imm, tbl[i].alu, tbl[i].r2, tbl[i].upc,
            tbl[i].wr, tbl[i].ld, tbl[i].st, tbl[i].br, tbl[i].ill, tbl[i].pc};
  endfunction

  function automatic logic [96:0] act();
    return {srcreg1_num, srcreg2_num, dstreg_num, imm, alucode, using_r2, using_pc,
            write_reg, info_load, info_store, info_branch, illegal, pc2};
  endfunction

  // drives one cycle from posedge+1; scoreboard pops on a transfer and pushes on an accept
  task automatic step(input int idx, input logic ordy, input logic fl);
    logic [96:0] e;
    int          j;
    in_valid  = (idx >= 0);
    in_ir     = (idx >= 0) ? tbl[idx].ir : 32'd0;
    in_pc     = (idx >= 0) ? tbl[idx].pc : 32'd0;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    if (out_valid && out_ready && !fl) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_extra actual=%h required=no output", act());
      end else begin
        j = sb.pop_front();
        e = exp_of(j);
        if (act() !== e) $display("FAIL sb_vec%0d actual=%h required=%h", j, act(), e);
        else passed++;
      end
    end
    if (in_valid && in_ready && !fl) sb.push_back(idx);
    @(posedge clk);
    #1;
    if (fl) sb.delete();
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 8 && (sb.size() != 0 || out_valid); k++) step(-1, 1'b1, 1'b0);
    checks++;
    if (sb.size() != 0 || out_valid) $display("FAIL %s_drain actual=%0d pending required=0", tag, sb.size());
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_ir = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid actual=%b required=0", out_valid);
    else passed++;
    checks++;
    if (act() !== 97'd0 || alucode !== ALU_UNUSED || info_load !== NOTLOAD ||
        info_store !== NOTSTORE || info_branch !== NOTBRANCH)
      $display("FAIL rst_fields actual=%h required=0", act());
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready actual=%b required=1", in_ready);
    else passed++;
  endtask

  task automatic test_addi();
    step(0, 1'b1, 1'b0);
    checks++;
    if ({out_valid, imm, alucode, dstreg_num, write_reg} !== {1'b1, 32'hFFFFFFFF, 5'(ALU_ADD), 5'd5, 1'b1})
      $display("FAIL addi_latency actual=%b/%h/%0d/%0d/%b required=1/ffffffff/%0d/5/1",
               out_valid, imm, alucode, dstreg_num, write_reg, ALU_ADD);
    else passed++;
    drain("addi");
  endtask

  task automatic test_branch();
    step(1, 1'b1, 1'b0);
    checks++;
    if ({info_branch, imm, using_pc, pc2, write_reg} !== {4'(BR_BEQ), 32'h8, 1'b1, 32'h100, 1'b0})
      $display("FAIL beq_fields actual=%0d/%h/%b/%h/%b required=%0d/8/1/100/0",
               info_branch, imm, using_pc, pc2, write_reg, BR_BEQ);
    else passed++;
    drain("beq");
  endtask

  task automatic test_m_ext();
    step(2, 1'b1, 1'b0);
    checks++;
`ifdef RV_M_EXT_EN
    if ({illegal, alucode, write_reg} !== {1'b0, 5'(ALU_MUL), 1'b0})
      $display("FAIL mul_decode actual=%b/%0d/%b required=0/%0d/0", illegal, alucode, write_reg, ALU_MUL);
    else passed++;
`else
    if ({illegal, alucode, write_reg} !== {1'b1, 5'(ALU_UNUSED), 1'b0})
      $display("FAIL mul_illegal actual=%b/%0d/%b required=1/%0d/0", illegal, alucode, write_reg, ALU_UNUSED);
    else passed++;
`endif
    drain("mul");
  endtask

  task automatic test_decode_table();
    for (int i = 0; i < tbl.size(); i++) step(i, 1'b1, 1'b0);
    drain("table");
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 3) != 0) ? int'($urandom_range(0, tbl.size() - 1)) : -1,
           1'($urandom_range(0, 1)), 1'b0);
    drain("random");
    checks++;
    if ({write_reg, info_load, info_store, info_branch, illegal} !== 10'd0)
      $display("FAIL idle_inactive actual=%b required=0",
               {write_reg, info_load, info_store, info_branch, illegal});
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [96:0] snap;
    step(3, 1'b0, 1'b0);
    step(4, 1'b0, 1'b0);
    checks++;
    if (in_ready !== 1'b0) $display("FAIL b2b_in_ready actual=%b required=0", in_ready);
    else passed++;
    snap = act();
    step(5, 1'b0, 1'b0);
    checks++;
    if (act() !== snap || out_valid !== 1'b1) $display("FAIL b2b_hold actual=%h required=%h", act(), snap);
    else passed++;
    step(5, 1'b1, 1'b0);
    step(5, 1'b1, 1'b0);
    drain("b2b");
  endtask

  task automatic test_flush();
    step(6, 1'b0, 1'b0);
    step(7, 1'b0, 1'b0);
    step(8, 1'b0, 1'b1);
    checks++;
    if ({out_valid, in_ready, write_reg, illegal} !== 4'b0100)
      $display("FAIL flush_state actual=%b required=0100", {out_valid, in_ready, write_reg, illegal});
    else passed++;
    repeat (4) step(-1, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_dropped actual=%b required=0", out_valid);
    else passed++;
    step(14, 1'b1, 1'b0);
    drain("post_flush");
  endtask

  task automatic test_reset_mid_stall();
    step(3, 1'b0, 1'b0);
    step(5, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL async_out_valid actual=%b required=0", out_valid);
    else passed++;
    checks++;
    if (act() !== 97'd0) $display("FAIL async_fields actual=%h required=0", act());
    else passed++;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL rst_release actual=%b%b required=10", in_ready, out_valid);
    else passed++;
    repeat (3) step(-1, 1'b1, 1'b0);
    step(15, 1'b1, 1'b0);
    drain("post_reset");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    build_table();
    test_reset();
    test_addi();
    test_branch();
    test_m_ext();
    test_decode_table();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
